st1_fetch: RTL and testbench

Instruction-fetch stage of the multi-cycle MIPS CPU. It is the producer side of the IF->ID interface. It holds the PC and drives the instruction-memory address. It captures the returned instruction and presents {pc, inst} on IF_ID_bus with IF_over. It consumes the decode stage's jbr_bus {jbr_taken, jbr_target} to choose the next PC. Sits between the stage-valid controller, the synchronous instruction ROM and st2_decode.

---
 rtl/st1_fetch_pkg.sv | 17 +
 rtl/st1_fetch.sv | 82 ++++++++
 tb/tb_st1_fetch.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/st1_fetch_pkg.sv
// Shared CPU definitions: inter-stage bus widths,
// fetch state encoding and the default reset PC.
package st1_fetch_pkg;

   localparam int IF_ID_BUS_W  = 64;
   localparam int JBR_BUS_W    = 33;
   localparam int ID_EXE_BUS_W = 150;

   localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

   typedef enum logic [2:0] {
      S_IDLE  = 3'b001,
      S_FETCH = 3'b010,
      S_DONE  = 3'b100
   } fetch_state_t;

endpackage

// File: rtl/st1_fetch.sv
// Instruction-fetch stage: holds the PC, waits out the ROM
// latency, then presents {pc, inst} to decode until retired.
module st1_fetch
   import st1_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = DEF_RESET_PC,
   parameter int          MEM_LATENCY = 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   IF_valid,
   input  logic                   next_fetch,
   input  logic [JBR_BUS_W-1:0]   jbr_bus,
   output logic [31:0]            inst_addr,
   input  logic [31:0]            inst_rdata,
   output logic                   IF_over,
   output logic [IF_ID_BUS_W-1:0] IF_ID_bus,
   output logic [31:0]            IF_pc
);

   localparam logic [1:0] CNT_LAST = 2'(MEM_LATENCY - 1);

   fetch_state_t state;
   logic [31:0]  pc;
   logic [31:0]  inst_r;
   logic [1:0]   cnt;

   logic         jbr_taken;
   logic [31:0]  jbr_target;
   logic [31:0]  pc_next;

   assign jbr_taken  = jbr_bus[32];
   assign jbr_target = jbr_bus[31:0];
   assign pc_next    = jbr_taken ? jbr_target : pc + 32'd4;

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         inst_r  <= '0;
         state   <= S_IDLE;
         cnt     <= '0;
         IF_over <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (IF_valid) begin
                  state <= S_FETCH;
                  cnt   <= '0;
               end
            end
            S_FETCH: begin
               if (!IF_valid) begin
                  state <= S_IDLE;
               end else if (cnt == CNT_LAST) begin
                  inst_r  <= inst_rdata;
                  state   <= S_DONE;
                  IF_over <= 1'b1;
               end else begin
                  cnt <= cnt + 2'd1;
               end
            end
            S_DONE: begin
               // only a retire moves on; IF_valid is ignored here
               if (next_fetch) begin
                  pc      <= pc_next;
                  state   <= S_IDLE;
                  IF_over <= 1'b0;
               end
            end
            default: begin
               state   <= S_IDLE;
               IF_over <= 1'b0;
            end
         endcase
      end
   end

   assign inst_addr = pc;
   assign IF_pc     = pc;
   assign IF_ID_bus = {pc, inst_r};

endmodule

// File: tb/tb_st1_fetch.sv
// Directed bench for st1_fetch: a vector table for the
// latency-1 flow plus sequences for latency-3 and PC wrap.
module tb_st1_fetch;

   logic        clk = 1'b0;
   logic        reset;
   logic        IF_valid;
   logic        next_fetch;
   logic [32:0] jbr_bus;

   logic [31:0] addr_a, addr_b, addr_c;
   logic [31:0] rd_a, rd_b, rd_c;
   logic        ov_a, ov_b, ov_c;
   logic [63:0] bus_a, bus_b, bus_c;
   logic [31:0] pc_a, pc_b, pc_c;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_f(input logic [31:0] a);
      if (a == 32'h0) return 32'h2408_0005;
      return 32'hA500_0000 ^ a;
   endfunction

   always @(posedge clk) begin
      rd_a <= rom_f(addr_a);
      rd_b <= rom_f(addr_b);
      rd_c <= rom_f(addr_c);
   end

   st1_fetch #(.RESET_PC(32'h0), .MEM_LATENCY(1)) u_a (
      .clk(clk), .reset(reset), .IF_valid(IF_valid),
      .next_fetch(next_fetch), .jbr_bus(jbr_bus),
      .inst_addr(addr_a), .inst_rdata(rd_a), .IF_over(ov_a),
      .IF_ID_bus(bus_a), .IF_pc(pc_a)
   );

   st1_fetch #(.RESET_PC(32'h0), .MEM_LATENCY(3)) u_b (
      .clk(clk), .reset(reset), .IF_valid(IF_valid),
      .next_fetch(next_fetch), .jbr_bus(jbr_bus),
      .inst_addr(addr_b), .inst_rdata(rd_b), .IF_over(ov_b),
      .IF_ID_bus(bus_b), .IF_pc(pc_b)
   );

   st1_fetch #(.RESET_PC(32'hFFFF_FFFC), .MEM_LATENCY(1)) u_c (
      .clk(clk), .reset(reset), .IF_valid(IF_valid),
      .next_fetch(next_fetch), .jbr_bus(jbr_bus),
      .inst_addr(addr_c), .inst_rdata(rd_c), .IF_over(ov_c),
      .IF_ID_bus(bus_c), .IF_pc(pc_c)
   );

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic r, input logic iv,
                        input logic nf, input logic [32:0] j);
      reset      = r;
      IF_valid   = iv;
      next_fetch = nf;
      jbr_bus    = j;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic        rst;
      logic        iv;
      logic        nf;
      logic [32:0] jbr;
      logic        ov;
      logic [31:0] pc;
      logic [31:0] inst;
   } vec_t;

   vec_t tv[20];

   task automatic set_v(input int i, input logic r, input logic iv,
                        input logic nf, input logic [32:0] j,
                        input logic ov, input logic [31:0] p,
                        input logic [31:0] ins);
      tv[i].rst  = r;
      tv[i].iv   = iv;
      tv[i].nf   = nf;
      tv[i].jbr  = j;
      tv[i].ov   = ov;
      tv[i].pc   = p;
      tv[i].inst = ins;
   endtask

   initial begin
      logic [31:0] i0;
      i0 = 32'h2408_0005;
      //     idx rst iv nf jbr                    ov pc      inst
      set_v(0,  1, 0, 0, 33'h0,                0, 32'h0,  32'h0);
      set_v(1,  0, 1, 0, 33'h0,                0, 32'h0,  32'h0);
      set_v(2,  0, 1, 0, 33'h0,                1, 32'h0,  i0);
      set_v(3,  0, 1, 1, {1'b0, 32'hDEAD_BEE0}, 0, 32'h4,  i0);
      set_v(4,  0, 1, 0, 33'h0,                0, 32'h4,  i0);
      set_v(5,  0, 1, 0, 33'h0,                1, 32'h4,  rom_f(32'h4));
      set_v(6,  0, 1, 1, 33'h0,                0, 32'h8,  rom_f(32'h4));
      set_v(7,  0, 1, 0, 33'h0,                0, 32'h8,  rom_f(32'h4));
      set_v(8,  0, 1, 0, 33'h0,                1, 32'h8,  rom_f(32'h8));
      set_v(9,  0, 1, 1, 33'h0,                0, 32'hC,  rom_f(32'h8));
      set_v(10, 0, 1, 0, 33'h0,                0, 32'hC,  rom_f(32'h8));
      set_v(11, 0, 1, 0, 33'h0,                1, 32'hC,  rom_f(32'hC));
      set_v(12, 0, 1, 1, {1'b1, 32'h40},       0, 32'h40, rom_f(32'hC));
      set_v(13, 0, 1, 1, {1'b1, 32'h100},      0, 32'h40, rom_f(32'hC));
      set_v(14, 0, 1, 1, {1'b1, 32'h200},      1, 32'h40, rom_f(32'h40));
      set_v(15, 0, 0, 0, {1'b1, 32'h300},      1, 32'h40, rom_f(32'h40));
      set_v(16, 0, 0, 0, 33'h0,                1, 32'h40, rom_f(32'h40));
      set_v(17, 1, 0, 0, 33'h0,                0, 32'h0,  32'h0);
      set_v(18, 0, 1, 0, 33'h0,                0, 32'h0,  32'h0);
      set_v(19, 1, 1, 0, 33'h0,                0, 32'h0,  32'h0);

      drive(1, 0, 0, 33'h0);
      step();

      for (int i = 0; i < 20; i++) begin
         drive(tv[i].rst, tv[i].iv, tv[i].nf, tv[i].jbr);
         step();
         chk($sformatf("v%0d over", i), 64'(ov_a), 64'(tv[i].ov));
         chk($sformatf("v%0d addr", i), 64'(addr_a), 64'(tv[i].pc));
         chk($sformatf("v%0d ifpc", i), 64'(pc_a), 64'(tv[i].pc));
         chk($sformatf("v%0d bus", i), bus_a, {tv[i].pc, tv[i].inst});
      end

      // latency 3: IF_over exactly four edges after IF_valid sampled
      drive(1, 0, 0, 33'h0);
      step();
      chk("b reset bus", bus_b, 64'h0);
      drive(0, 1, 0, 33'h0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("b lat edge%0d", k), 64'(ov_b), 64'(k == 4));
      end
      chk("b inst0", bus_b, {32'h0, 32'h2408_0005});
      drive(0, 1, 1, 33'h0);
      step();
      chk("b pc4", 64'(pc_b), 64'h4);
      drive(0, 1, 0, 33'h0);
      step();
      step();
      drive(0, 0, 0, 33'h0);
      step();
      chk("b abort over", 64'(ov_b), 64'h0);
      chk("b abort pc", 64'(addr_b), 64'h4);
      step();
      step();
      step();
      chk("b idle over", 64'(ov_b), 64'h0);
      drive(0, 1, 0, 33'h0);
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("b relat edge%0d", k), 64'(ov_b), 64'(k == 4));
      end
      chk("b inst4", bus_b, {32'h4, rom_f(32'h4)});
      drive(1, 1, 0, 33'h0);
      step();
      chk("b rst done over", 64'(ov_b), 64'h0);
      chk("b rst done bus", bus_b, 64'h0);

      // wrap, ignored next_fetch in FETCH, unaligned jump target
      drive(1, 0, 0, 33'h0);
      step();
      chk("c reset bus", bus_c, {32'hFFFF_FFFC, 32'h0});
      drive(0, 1, 0, 33'h0);
      step();
      drive(0, 1, 1, {1'b1, 32'h0000_0800});
      step();
      chk("c nf in fetch over", 64'(ov_c), 64'h1);
      chk("c nf in fetch pc", 64'(pc_c), 64'hFFFF_FFFC);
      chk("c inst", 64'(bus_c[31:0]), 64'(rom_f(32'hFFFF_FFFC)));
      drive(0, 1, 1, {1'b0, 32'h0000_0800});
      step();
      chk("c wrap pc", 64'(addr_c), 64'h0);
      chk("c wrap over", 64'(ov_c), 64'h0);
      drive(0, 1, 0, 33'h0);
      step();
      step();
      drive(0, 1, 1, {1'b1, 32'h0000_0043});
      step();
      chk("c jump raw", 64'(pc_c), 64'h43);
      drive(0, 1, 0, 33'h0);
      step();
      drive(1, 1, 0, 33'h0);
      step();
      chk("c rst fetch pc", 64'(pc_c), 64'hFFFF_FFFC);
      chk("c rst fetch bus", bus_c, {32'hFFFF_FFFC, 32'h0});
      chk("c rst fetch over", 64'(ov_c), 64'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
